// File: rtl/aoi_eval_pipe.sv
// Parametrised AND-OR / OR-AND evaluator with a valid/ready pipeline and
// saturating result statistics. Mode 0 with two 2-input groups reproduces
// the legacy two-term AOI cell bit for bit.
module aoi_eval_pipe #(
    parameter int unsigned NUM_TERMS   = 2,
    parameter int unsigned TERM_WIDTH  = 2,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_TERMS*TERM_WIDTH-1:0] in_a,
    input  logic                            in_b,
    input  logic [1:0]                      in_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_x,
    output logic [NUM_TERMS-1:0]            out_terms,
    input  logic                            cnt_clr,
    output logic [CNT_WIDTH-1:0]            cnt_beats,
    output logic [CNT_WIDTH-1:0]            cnt_ones
);

    typedef enum logic [1:0] {
        MODE_AOI = 2'd0,
        MODE_AO  = 2'd1,
        MODE_OAI = 2'd2,
        MODE_OA  = 2'd3
    } mode_e;

    mode_e                mode;
    logic                 en;
    logic                 handshake;
    logic [NUM_TERMS-1:0] terms_d;
    logic                 x_d;

    // Stage i holds one beat: valid flag, per-group terms and final result.
    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] x_q;
    logic [NUM_TERMS-1:0]   terms_q [PIPE_STAGES];

    logic [CNT_WIDTH-1:0] beats_q;
    logic [CNT_WIDTH-1:0] beats_d;
    logic [CNT_WIDTH-1:0] ones_q;
    logic [CNT_WIDTH-1:0] ones_d;

    // The whole pipeline advances in lockstep; only a held output stalls it.
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign handshake = out_valid & out_ready;
    assign mode      = mode_e'(in_mode);

    // Per-group reduction: AND for the AND-OR modes, OR for the OR-AND modes.
    always_comb begin
        terms_d = '0;
        for (int unsigned g = 0; g < NUM_TERMS; g++) begin
            if (mode == MODE_OAI || mode == MODE_OA) begin
                terms_d[g] = |in_a[g*TERM_WIDTH +: TERM_WIDTH];
            end else begin
                terms_d[g] = &in_a[g*TERM_WIDTH +: TERM_WIDTH];
            end
        end
    end

    // Combine the group terms with B; evaluated before stage 1 so that
    // PIPE_STAGES=1 still presents a registered result.
    always_comb begin
        x_d = 1'b0;
        case (mode)
            MODE_AOI: x_d = ~((|terms_d) | in_b);
            MODE_AO:  x_d =  (|terms_d) | in_b;
            MODE_OAI: x_d = ~((&terms_d) & in_b);
            MODE_OA:  x_d =  (&terms_d) & in_b;
            default:  x_d = 1'b0;
        endcase
    end

    // Pipeline shift; data only follows valid beats so bubbles leave the
    // previous result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            x_q   <= '0;
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                terms_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                x_q[0]     <= x_d;
                terms_q[0] <= terms_d;
            end
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    x_q[i]     <= x_q[i-1];
                    terms_q[i] <= terms_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign out_x     = x_q[PIPE_STAGES-1];
    assign out_terms = terms_q[PIPE_STAGES-1];

    // Saturating statistics; clear wins over a same-cycle handshake.
    always_comb begin
        beats_d = beats_q;
        ones_d  = ones_q;
        if (cnt_clr) begin
            beats_d = '0;
            ones_d  = '0;
        end else if (handshake) begin
            if (beats_q != '1) begin
                beats_d = beats_q + 1'b1;
            end
            if (out_x && (ones_q != '1)) begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_q <= '0;
            ones_q  <= '0;
        end else begin
            beats_q <= beats_d;
            ones_q  <= ones_d;
        end
    end

    assign cnt_beats = beats_q;
    assign cnt_ones  = ones_q;

endmodule

// File: tb/tb_aoi_eval_pipe.sv
// Self-checking bench for aoi_eval_pipe: default instance driven by table
// vectors, an exhaustive mode-0 stream, backpressure, mid-stream reset and
// random traffic; plus a 2-bit-counter instance and a 3x3, 4-stage instance.
module tb_aoi_eval_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic        in_valid, in_ready, in_b, out_valid, out_ready, out_x, cnt_clr;
    logic [3:0]  in_a;
    logic [1:0]  in_mode, out_terms;
    logic [15:0] cnt_beats, cnt_ones;

    // Saturation instance (CNT_WIDTH=2)
    logic       s_in_valid, s_in_ready, s_in_b, s_out_valid, s_out_x, s_cnt_clr;
    logic       s_out_ready;
    logic [3:0] s_in_a;
    logic [1:0] s_in_mode, s_out_terms, s_cnt_beats, s_cnt_ones;

    // Wide instance (3 groups x 3 bits, 4 stages)
    logic        w_in_valid, w_in_ready, w_in_b, w_out_valid, w_out_x, w_cnt_clr;
    logic        w_out_ready;
    logic [8:0]  w_in_a;
    logic [1:0]  w_in_mode;
    logic [2:0]  w_out_terms;
    logic [15:0] w_cnt_beats, w_cnt_ones;

    aoi_eval_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_terms(out_terms),
        .cnt_clr(cnt_clr), .cnt_beats(cnt_beats), .cnt_ones(cnt_ones)
    );

    aoi_eval_pipe #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_mode(s_in_mode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_x(s_out_x), .out_terms(s_out_terms),
        .cnt_clr(s_cnt_clr), .cnt_beats(s_cnt_beats), .cnt_ones(s_cnt_ones)
    );

    aoi_eval_pipe #(.NUM_TERMS(3), .TERM_WIDTH(3), .PIPE_STAGES(4)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_mode(w_in_mode), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_x(w_out_x), .out_terms(w_out_terms),
        .cnt_clr(w_cnt_clr), .cnt_beats(w_cnt_beats), .cnt_ones(w_cnt_ones)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s got=event exp=none at %0t", name, $time);
    endtask

    // Reference model of one beat for the default 2x2 geometry.
    typedef struct packed {
        logic       x;
        logic [1:0] terms;
    } exp_t;

    function automatic exp_t model_eval(input logic [1:0] m, input logic [3:0] a, input logic b);
        int unsigned grp;
        int unsigned tv;
        bit          anyt;
        bit          allt;
        exp_t        r;
        tv = 0;
        for (int g = 0; g < 2; g++) begin
            grp = (int'(a) >> (2 * g)) % 4;
            if (m >= 2) begin
                if (grp != 0) tv = tv + (1 << g);
            end else begin
                if (grp == 3) tv = tv + (1 << g);
            end
        end
        anyt = (tv != 0);
        allt = (tv == 3);
        case (m)
            2'd0:    r.x = !(anyt || b);
            2'd1:    r.x = anyt || b;
            2'd2:    r.x = !(allt && b);
            default: r.x = allt && b;
        endcase
        r.terms = 2'(tv);
        return r;
    endfunction

    // out_ready driver: forced stalls, random, or always ready.
    int  cyc         = 0;
    int  stall_until = 0;
    bit  rand_ready  = 1'b0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (cyc <= stall_until) out_ready = 1'b0;
            else if (rand_ready)    out_ready = 1'($urandom_range(0, 1));
            else                    out_ready = 1'b1;
        end
    end

    // Monitor for the default instance: scoreboard, counters, stability.
    exp_t        sbq[$];
    bit          hold_p = 1'b0;
    logic        hold_x;
    logic [1:0]  hold_t;
    int unsigned m_beats = 0;
    int unsigned m_ones  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            m_beats = 0;
            m_ones  = 0;
            hold_p  = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_cnt_beats", cnt_beats, 0);
        end else begin
            check("cnt_beats", cnt_beats, m_beats);
            check("cnt_ones", cnt_ones, m_ones);
            if (hold_p) begin
                check("hold_valid", out_valid, 1);
                check("hold_x", out_x, hold_x);
                check("hold_terms", out_terms, hold_t);
            end
            hold_p = out_valid && !out_ready;
            hold_x = out_x;
            hold_t = out_terms;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    fail_now("sb_extra_beat");
                end else begin
                    e = sbq.pop_front();
                    check("sb_x", out_x, e.x);
                    check("sb_terms", out_terms, e.terms);
                end
            end
            if (cnt_clr) begin
                m_beats = 0;
                m_ones  = 0;
            end else if (out_valid && out_ready) begin
                if (m_beats < 65535) m_beats++;
                if (out_x && m_ones < 65535) m_ones++;
            end
            if (in_valid && in_ready) sbq.push_back(model_eval(in_mode, in_a, in_b));
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_beat(input logic [1:0] m, input logic [3:0] a, input logic b);
        int unsigned n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) fail_now("accept_timeout");
    endtask

    task automatic expect_main(input string nm, input int lat_exp, input logic x, input logic [1:0] t);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_lat"}, lat, lat_exp);
        check({nm, "_x"}, out_x, x);
        check({nm, "_terms"}, out_terms, t);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sbq.size(), 0);
    endtask

    task automatic wide_beat(input logic [1:0] m, input logic [8:0] a, input logic b,
                             input logic x, input logic [2:0] t);
        int lat = 0;
        w_in_valid = 1'b1;
        w_in_mode  = m;
        w_in_a     = a;
        w_in_b     = b;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("wide_lat", lat, 3);
        check("wide_x", w_out_x, x);
        check("wide_terms", w_out_terms, t);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] a;
        logic       b;
        logic       x;
        logic [1:0] terms;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{2'd0, 4'b0000, 1'b0, 1'b1, 2'b00};
        tbl[1]  = '{2'd0, 4'b0011, 1'b0, 1'b0, 2'b01};
        tbl[2]  = '{2'd0, 4'b1100, 1'b0, 1'b0, 2'b10};
        tbl[3]  = '{2'd0, 4'b0000, 1'b1, 1'b0, 2'b00};
        tbl[4]  = '{2'd1, 4'b0110, 1'b1, 1'b1, 2'b00};
        tbl[5]  = '{2'd2, 4'b0110, 1'b1, 1'b0, 2'b11};
        tbl[6]  = '{2'd3, 4'b0110, 1'b1, 1'b1, 2'b11};
        tbl[7]  = '{2'd1, 4'b1111, 1'b0, 1'b1, 2'b11};
        tbl[8]  = '{2'd3, 4'b0110, 1'b0, 1'b0, 2'b11};
        tbl[9]  = '{2'd2, 4'b0100, 1'b1, 1'b1, 2'b10};
        tbl[10] = '{2'd3, 4'b1101, 1'b1, 1'b1, 2'b11};
        tbl[11] = '{2'd1, 4'b0000, 1'b0, 1'b0, 2'b00};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = 1'b0; in_mode = '0; cnt_clr = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = 1'b0; s_in_mode = '0; s_cnt_clr = 1'b0;
        s_out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = 1'b0; w_in_mode = '0; w_cnt_clr = 1'b0;
        w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_out_valid", out_valid, 0);
        check("reset_out_x", out_x, 0);
        check("reset_out_terms", out_terms, 0);
        check("reset_cnt_beats", cnt_beats, 0);
        check("reset_cnt_ones", cnt_ones, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_w_in_ready", w_in_ready, 1);

        // Table vectors, one beat at a time
        for (int i = 0; i < 12; i++) begin
            send_beat(tbl[i].mode, tbl[i].a, tbl[i].b);
            expect_main("tbl", 1, tbl[i].x, tbl[i].terms);
        end
        drain();

        // Exhaustive mode-0 stream from cleared counters
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            send_beat(2'd0, v[3:0], v[4]);
        end
        drain();
        check("exh_cnt_beats", cnt_beats, 32);
        check("exh_cnt_ones", cnt_ones, 9);

        // Backpressure: 5 stalled cycles during a 4-beat stream
        send_beat(2'd0, 4'b0000, 1'b0);
        stall_until = cyc + 5;
        send_beat(2'd0, 4'b0011, 1'b0);
        @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        send_beat(2'd3, 4'b0110, 1'b1);
        send_beat(2'd1, 4'b1100, 1'b0);
        drain();
        check("bp_cnt_beats", cnt_beats, 36);

        // Reset with two beats in flight
        send_beat(2'd0, 4'b0000, 1'b0);
        send_beat(2'd1, 4'b0000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_cnt_beats", cnt_beats, 0);
        check("mid_rst_cnt_ones", cnt_ones, 0);
        check("mid_rst_out_x", out_x, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(2'd1, 4'b0000, 1'b1);
        expect_main("post_rst", 1, 1'b1, 2'b00);
        drain();

        // Random traffic with random backpressure and occasional clears
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cnt_clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) != 0) begin
                send_beat(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        cnt_clr    = 1'b0;
        rand_ready = 1'b0;
        drain();

        // Saturation on 2-bit counters
        s_in_mode  = 2'd1;
        s_in_a     = 4'b0000;
        s_in_b     = 1'b1;
        s_in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_beats", s_cnt_beats, 3);
        check("sat_ones", s_cnt_ones, 3);
        check("sat_terms", s_out_terms, 2'b00);
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat_clr_valid", s_out_valid, 1);
        check("sat_clr_in_ready", s_in_ready, 1);
        s_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        s_cnt_clr = 1'b0;
        check("sat_clr_beats", s_cnt_beats, 0);
        check("sat_clr_ones", s_cnt_ones, 0);
        s_in_mode  = 2'd0;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sat_after_beats", s_cnt_beats, 1);
        check("sat_after_ones", s_cnt_ones, 0);
        check("sat_after_x", s_out_x, 0);

        // 3x3 groups, 4 stages
        wide_beat(2'd0, 9'b111_000_000, 1'b0, 1'b0, 3'b100);
        wide_beat(2'd2, 9'b011_101_110, 1'b1, 1'b0, 3'b111);
        wide_beat(2'd0, 9'b000_000_000, 1'b0, 1'b1, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("wide_cnt_beats", w_cnt_beats, 3);
        check("wide_cnt_ones", w_cnt_ones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
